// File: rtl/int_request_ctrl.sv
// Interrupt request controller: edge-detects three request lines, holds them pending,
// and arbitrates by fixed priority with nesting ahead of the ID/EX register.
module int_request_ctrl #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] VEC0       = 32'h0000_3000,
  parameter logic [WIDTH-1:0] VEC1       = 32'h0000_3100,
  parameter logic [WIDTH-1:0] VEC2       = 32'h0000_3200,
  parameter int unsigned      ENTRY_HOLD = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       irq_in,
  input  logic             ie_in,
  input  logic             id_valid_in,
  input  logic             uret_in,
  output logic             Int_Enter,
  output logic [2:0]       IRS,
  output logic [WIDTH-1:0] t,
  output logic [2:0]       pending,
  output logic [2:0]       in_service
);

  localparam logic [2:0] HOLD_LOAD = 3'(ENTRY_HOLD);

  logic [2:0]       r_irq_d;
  logic [2:0]       r_pending;
  logic [2:0]       r_in_service;
  logic [2:0]       r_hold_cnt;

  logic [2:0]       w_edge;
  logic [2:0]       w_above;
  logic [2:0]       w_top_oh;
  logic [2:0]       w_cand;
  logic [2:0]       w_sel_oh;
  logic [WIDTH-1:0] w_sel_vec;
  logic             w_accept;
  logic             w_ret;
  logic [2:0]       w_acc_set;
  logic [2:0]       w_ret_clr;

  always_comb begin
    w_edge = irq_in & ~r_irq_d;

    // w_above masks off every source at or below the current in-service level
    w_above  = 3'b111;
    w_top_oh = '0;
    if (r_in_service[2]) begin
      w_above  = 3'b000;
      w_top_oh = 3'b100;
    end else if (r_in_service[1]) begin
      w_above  = 3'b100;
      w_top_oh = 3'b010;
    end else if (r_in_service[0]) begin
      w_above  = 3'b110;
      w_top_oh = 3'b001;
    end

    w_cand    = r_pending & w_above;
    w_sel_oh  = '0;
    w_sel_vec = '0;
    if (w_cand[2]) begin
      w_sel_oh  = 3'b100;
      w_sel_vec = VEC2;
    end else if (w_cand[1]) begin
      w_sel_oh  = 3'b010;
      w_sel_vec = VEC1;
    end else if (w_cand[0]) begin
      w_sel_oh  = 3'b001;
      w_sel_vec = VEC0;
    end

    Int_Enter = ie_in & id_valid_in & (r_hold_cnt == '0) & (|w_cand);
    IRS       = Int_Enter ? w_sel_oh : '0;
    t         = Int_Enter ? w_sel_vec : '0;

    w_accept  = Int_Enter & en;
    w_ret     = uret_in & en;
    w_acc_set = {3{w_accept}} & w_sel_oh;
    w_ret_clr = {3{w_ret}} & w_top_oh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_d      <= '0;
      r_pending    <= '0;
      r_in_service <= '0;
      r_hold_cnt   <= '0;
    end else begin
      r_irq_d      <= irq_in;
      // a fresh edge on the source being accepted keeps it pending
      r_pending    <= (r_pending & ~w_acc_set) | w_edge;
      // uret clears the old top level first, then the accepted level is set
      r_in_service <= (r_in_service & ~w_ret_clr) | w_acc_set;
      if (w_accept) begin
        r_hold_cnt <= HOLD_LOAD;
      end else if (r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - 3'd1;
      end
    end
  end

  assign pending    = r_pending;
  assign in_service = r_in_service;

endmodule

// File: tb/tb_int_request_ctrl.sv
// Self-checking bench for int_request_ctrl: a stack-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_int_request_ctrl;

  localparam int ENTRY_HOLD = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  irq_in;
  logic        ie_in;
  logic        id_valid_in;
  logic        uret_in;
  logic        Int_Enter;
  logic [2:0]  IRS;
  logic [31:0] t;
  logic [2:0]  pending;
  logic [2:0]  in_service;

  int total = 0;
  int bad   = 0;

  logic [31:0] vec [3] = '{32'h0000_3000, 32'h0000_3100, 32'h0000_3200};

  int_request_ctrl #(
    .WIDTH(32),
    .VEC0(32'h0000_3000),
    .VEC1(32'h0000_3100),
    .VEC2(32'h0000_3200),
    .ENTRY_HOLD(ENTRY_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .irq_in(irq_in),
    .ie_in(ie_in),
    .id_valid_in(id_valid_in),
    .uret_in(uret_in),
    .Int_Enter(Int_Enter),
    .IRS(IRS),
    .t(t),
    .pending(pending),
    .in_service(in_service)
  );

  always #5 clk = ~clk;

  // Reference model: pending as a bit set, nesting as a stack of source numbers
  bit [2:0] m_pend;
  bit [2:0] m_prev;
  int       m_stack[$];
  int       m_hold;
  bit       m_valid = 1'b0;

  function automatic int m_sel();
    int top;
    top = (m_stack.size() == 0) ? -1 : m_stack[$];
    for (int i = 2; i > top; i--)
      if (m_pend[i]) return i;
    return -1;
  endfunction

  function automatic bit m_enter();
    return ie_in && id_valid_in && (m_hold == 0) && (m_sel() >= 0);
  endfunction

  function automatic logic [2:0] m_is();
    logic [2:0] v;
    v = '0;
    foreach (m_stack[k]) v[m_stack[k]] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model_upd
    int  s;
    bit  acc;
    if (rst) begin
      m_pend  = '0;
      m_prev  = '0;
      m_stack.delete();
      m_hold  = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      s   = m_sel();
      acc = m_enter() && en;
      if (uret_in && en && m_stack.size() > 0) void'(m_stack.pop_back());
      if (acc) begin
        m_stack.push_back(s);
        m_pend[s] = 1'b0;
      end
      m_pend = m_pend | (irq_in & ~m_prev);
      if (acc) m_hold = ENTRY_HOLD;
      else if (m_hold > 0) m_hold--;
      m_prev = irq_in;
    end
  end

  always @(negedge clk) begin : compare
    int          s;
    bit          e;
    logic [2:0]  exp_irs;
    logic [31:0] exp_t;
    if (m_valid) begin
      s       = m_sel();
      e       = m_enter();
      exp_irs = '0;
      exp_t   = '0;
      if (e) begin
        exp_irs[s] = 1'b1;
        exp_t      = vec[s];
      end
      chk("model_enter", 32'(Int_Enter), 32'(e));
      chk("model_irs", 32'(IRS), 32'(exp_irs));
      chk("model_t", t, exp_t);
      chk("model_pending", 32'(pending), 32'(m_pend));
      chk("model_in_service", 32'(in_service), 32'(m_is()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit_out(input string name, input logic ent, input logic [2:0] irs,
                         input logic [31:0] tv, input logic [2:0] pend, input logic [2:0] isv);
    #1;
    chk({name, ".enter"}, 32'(Int_Enter), 32'(ent));
    chk({name, ".irs"}, 32'(IRS), 32'(irs));
    chk({name, ".t"}, t, tv);
    chk({name, ".pending"}, 32'(pending), 32'(pend));
    chk({name, ".in_service"}, 32'(in_service), 32'(isv));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; en = 1'b1; ie_in = 1'b1; id_valid_in = 1'b1; uret_in = 1'b0; irq_in = '0;
    tick(); tick();
    rst = 1'b0;
    lit_out("reset", 1'b0, 3'b000, 32'h0, 3'b000, 3'b000);

    // basic entry on source 0
    irq_in = 3'b001;
    lit_out("edge_cycle", 1'b0, 3'b000, 32'h0, 3'b000, 3'b000);
    tick();
    lit_out("entry0", 1'b1, 3'b001, 32'h3000, 3'b001, 3'b000);
    tick();
    irq_in = 3'b011;
    lit_out("after_accept0", 1'b0, 3'b000, 32'h0, 3'b000, 3'b001);
    tick();
    lit_out("hold2_blocks", 1'b0, 3'b000, 32'h0, 3'b010, 3'b001);
    tick();
    lit_out("hold1_blocks", 1'b0, 3'b000, 32'h0, 3'b010, 3'b001);
    tick();
    lit_out("nest_entry1", 1'b1, 3'b010, 32'h3100, 3'b010, 3'b001);
    tick();
    irq_in = 3'b000;
    lit_out("nested", 1'b0, 3'b000, 32'h0, 3'b000, 3'b011);
    uret_in = 1'b1;
    tick();
    lit_out("uret1", 1'b0, 3'b000, 32'h0, 3'b000, 3'b001);
    tick();
    uret_in = 1'b0;
    lit_out("uret0", 1'b0, 3'b000, 32'h0, 3'b000, 3'b000);

    // priority: sources 0 and 2 together
    irq_in = 3'b101;
    tick();
    lit_out("prio_entry2", 1'b1, 3'b100, 32'h3200, 3'b101, 3'b000);
    tick();
    irq_in = 3'b000;
    for (int i = 0; i < 5; i++) begin
      lit_out("low_blocked", 1'b0, 3'b000, 32'h0, 3'b001, 3'b100);
      tick();
    end
    uret_in = 1'b1;
    tick();
    uret_in = 1'b0;
    lit_out("low_after_uret", 1'b1, 3'b001, 32'h3000, 3'b001, 3'b000);
    tick();
    uret_in = 1'b1;
    tick();
    uret_in = 1'b0;
    repeat (4) tick();

    // stall: entry held while en=0, accepted once when en returns
    irq_in = 3'b100; en = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      lit_out("stall", 1'b1, 3'b100, 32'h3200, 3'b100, 3'b000);
      tick();
    end
    en = 1'b1;
    tick();
    irq_in = 3'b000;
    for (int i = 0; i < 5; i++) begin
      lit_out("accepted_once", 1'b0, 3'b000, 32'h0, 3'b000, 3'b100);
      tick();
    end

    // gating and same-priority re-edge
    irq_in = 3'b100;
    tick();
    lit_out("same_prio", 1'b0, 3'b000, 32'h0, 3'b100, 3'b100);
    uret_in = 1'b1;
    tick();
    uret_in = 1'b0;
    ie_in = 1'b0;
    lit_out("ie_gate", 1'b0, 3'b000, 32'h0, 3'b100, 3'b000);
    ie_in = 1'b1; id_valid_in = 1'b0;
    lit_out("idv_gate", 1'b0, 3'b000, 32'h0, 3'b100, 3'b000);
    id_valid_in = 1'b1;
    lit_out("ungated", 1'b1, 3'b100, 32'h3200, 3'b100, 3'b000);
    tick();
    irq_in = 3'b000;
    uret_in = 1'b1;
    tick();
    uret_in = 1'b0;
    repeat (4) tick();

    // uret and accept in the same cycle, then reset mid-hold
    irq_in = 3'b010;
    tick();
    tick();
    repeat (4) tick();
    irq_in = 3'b110;
    tick();
    uret_in = 1'b1;
    lit_out("uret_and_accept", 1'b1, 3'b100, 32'h3200, 3'b100, 3'b010);
    tick();
    uret_in = 1'b0;
    lit_out("swap_level", 1'b0, 3'b000, 32'h0, 3'b000, 3'b100);
    rst = 1'b1; irq_in = 3'b000;
    tick();
    lit_out("rst_mid_hold", 1'b0, 3'b000, 32'h0, 3'b000, 3'b000);
    rst = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
